// File: rtl/icache_set_array_if.sv
// icache_set_array_if
//   Lookup, fill and flush signals between the icache control FSM / line-fill
//   path (master) and the set-associative storage core (slave).
//   Lookup : rindex, rtag, access_en -> hit, hit_way, rdata, victim_way
//   Fill   : fill_en, windex, fill_way, fill_tag, fill_data
//   Flush  : flush_req -> busy, flush_done
interface icache_set_array_if #(
    parameter int WIDTH   = 256,
    parameter int TAG_W   = 24,
    parameter int S_INDEX = 6,
    parameter int WAYS    = 2
) ();
    localparam int WB = $clog2(WAYS);

    logic [S_INDEX-1:0] rindex;
    logic [TAG_W-1:0]   rtag;
    logic               access_en;
    logic               hit;
    logic [WB-1:0]      hit_way;
    logic [WIDTH-1:0]   rdata;
    logic [WB-1:0]      victim_way;
    logic               fill_en;
    logic [S_INDEX-1:0] windex;
    logic [WB-1:0]      fill_way;
    logic [TAG_W-1:0]   fill_tag;
    logic [WIDTH-1:0]   fill_data;
    logic               flush_req;
    logic               busy;
    logic               flush_done;

    modport master (
        output rindex, rtag, access_en, fill_en, windex, fill_way, fill_tag,
               fill_data, flush_req,
        input  hit, hit_way, rdata, victim_way, busy, flush_done
    );

    modport slave (
        input  rindex, rtag, access_en, fill_en, windex, fill_way, fill_tag,
               fill_data, flush_req,
        output hit, hit_way, rdata, victim_way, busy, flush_done
    );
endinterface

// File: rtl/icache_set_array.sv
// icache_set_array
//   Set-associative storage core: per-way data/tag arrays, per-line valid
//   bits, per-set tree pseudo-LRU, combinational lookup with fill forward,
//   victim selection and a one-set-per-cycle invalidate-all sweep.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (valid, plru, FSM)
//   bus   : icache_set_array_if.slave (lookup / fill / flush signals)
module icache_set_array #(
    parameter int WIDTH   = 256,
    parameter int TAG_W   = 24,
    parameter int S_INDEX = 6,
    parameter int WAYS    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    icache_set_array_if.slave bus
);
    localparam int SETS = 2**S_INDEX;
    localparam int WB   = $clog2(WAYS);
    localparam int PW   = WAYS - 1;

    typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

    state_t             r_state, w_state_next;
    logic [S_INDEX-1:0] r_cnt;
    logic               r_flush_done, w_flush_done_next;
    logic               w_busy;

    logic [WIDTH-1:0]   r_data  [WAYS][SETS];
    logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
    logic [SETS-1:0]    r_valid [WAYS];
    logic [PW-1:0]      r_plru  [SETS];

    // Per-way constant tables over the heap-ordered PLRU tree (node n has
    // children 2n+1 / 2n+2). w_pmask marks the nodes on the way's path;
    // w_pval holds the bit values that point each of those nodes away from
    // the way (1 = LRU side is the upper half).
    logic [PW-1:0]      w_pmask [WAYS];
    logic [PW-1:0]      w_pval  [WAYS];

    genvar gi, gj;
    for (gi = 0; gi < WAYS; gi++) begin : g_path_way
        for (gj = 0; gj < PW; gj++) begin : g_path_node
            localparam int LVL      = $clog2(gj + 2) - 1;
            localparam int POS      = gj - (2**LVL - 1);
            localparam bit ON_PATH  = ((gi >> (WB - LVL)) == POS);
            localparam bit GO_UPPER = (((gi >> (WB - 1 - LVL)) % 2) == 1);
            assign w_pmask[gi][gj] = ON_PATH;
            assign w_pval[gi][gj]  = ON_PATH && !GO_UPPER;
        end
    end

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p,
                                                 input logic [PW-1:0] m,
                                                 input logic [PW-1:0] v);
        return (p & ~m) | (v & m);
    endfunction

    // ---------------- lookup with fill forward ----------------
    logic               w_fwd;
    logic [WAYS-1:0]    w_eff_valid, w_match, w_leaf;
    logic [TAG_W-1:0]   w_eff_tag  [WAYS];
    logic [WIDTH-1:0]   w_eff_data [WAYS];
    logic [PW-1:0]      w_plru_rd;

    assign w_busy    = (r_state == ST_FLUSH);
    assign w_fwd     = bus.fill_en && !w_busy && (bus.windex == bus.rindex);
    assign w_plru_rd = r_plru[bus.rindex];

    for (gi = 0; gi < WAYS; gi++) begin : g_way
        logic w_fwd_way;
        assign w_fwd_way       = w_fwd && (bus.fill_way == WB'(gi));
        assign w_eff_valid[gi] = w_fwd_way | r_valid[gi][bus.rindex];
        assign w_eff_tag[gi]   = w_fwd_way ? bus.fill_tag  : r_tag[gi][bus.rindex];
        assign w_eff_data[gi]  = w_fwd_way ? bus.fill_data : r_data[gi][bus.rindex];
        assign w_match[gi]     = w_eff_valid[gi] && !w_busy &&
                                 (w_eff_tag[gi] == bus.rtag);
        // Exactly one leaf satisfies every node on its path pointing at it.
        assign w_leaf[gi]      = ((w_plru_rd & w_pmask[gi]) ==
                                  (~w_pval[gi] & w_pmask[gi]));
    end

    logic               w_hit, w_any_inv;
    logic [WB-1:0]      w_hit_way, w_inv_way, w_leaf_way, w_victim_way;
    logic [WIDTH-1:0]   w_rdata;

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_rdata    = '0;
        w_any_inv  = 1'b0;
        w_inv_way  = '0;
        w_leaf_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_way = WB'(i);
                w_rdata   = w_eff_data[i];
            end
            if (!w_eff_valid[i]) begin
                w_any_inv = 1'b1;
                w_inv_way = WB'(i);
            end
            if (w_leaf[i]) begin
                w_leaf_way = WB'(i);
            end
        end
        w_victim_way = w_any_inv ? w_inv_way : w_leaf_way;
    end

    // ---------------- PLRU update ----------------
    logic               w_acc_touch, w_fill_ok;
    logic [PW-1:0]      w_plru_acc, w_plru_fill_base, w_plru_fill;

    assign w_acc_touch      = bus.access_en && w_hit;
    assign w_fill_ok        = bus.fill_en && !w_busy;
    assign w_plru_acc       = plru_touch(w_plru_rd, w_pmask[w_hit_way], w_pval[w_hit_way]);
    // Same-set access and fill: chain the fill touch after the access touch
    // so the filled way ends up MRU.
    assign w_plru_fill_base = (w_acc_touch && (bus.windex == bus.rindex)) ?
                              w_plru_acc : r_plru[bus.windex];
    assign w_plru_fill      = plru_touch(w_plru_fill_base, w_pmask[bus.fill_way],
                                         w_pval[bus.fill_way]);

    // ---------------- flush FSM ----------------
    always_comb begin
        w_state_next      = r_state;
        w_flush_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (&r_cnt) begin
                    w_state_next      = ST_IDLE;
                    w_flush_done_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_flush_done <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                r_valid[i] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_flush_done <= w_flush_done_next;
            if (w_busy) begin
                // Counter wraps back to 0 as the last set is cleared.
                r_cnt <= r_cnt + 1'b1;
                for (int i = 0; i < WAYS; i++) begin
                    r_valid[i][r_cnt] <= 1'b0;
                end
                r_plru[r_cnt] <= '0;
            end else begin
                if (w_acc_touch) begin
                    r_plru[bus.rindex] <= w_plru_acc;
                end
                // Later assignment wins when both hit the same set.
                if (w_fill_ok) begin
                    r_valid[bus.fill_way][bus.windex] <= 1'b1;
                    r_plru[bus.windex]                <= w_plru_fill;
                end
            end
        end
    end

    // Data and tag are never reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (w_fill_ok) begin
            r_data[bus.fill_way][bus.windex] <= bus.fill_data;
            r_tag[bus.fill_way][bus.windex]  <= bus.fill_tag;
        end
    end

    assign bus.hit        = w_hit;
    assign bus.hit_way    = w_hit_way;
    assign bus.rdata      = w_rdata;
    assign bus.victim_way = w_victim_way;
    assign bus.busy       = w_busy;
    assign bus.flush_done = r_flush_done;
endmodule

// File: tb/tb_icache_set_array.sv
module tb_icache_set_array;
    localparam int WIDTH   = 256;
    localparam int TAG_W   = 24;
    localparam int S_INDEX = 6;
    localparam int WAYS    = 4;
    localparam int SETS    = 64;

    localparam logic [255:0] D_BEEF = {8{32'hDEADBEEF}};

    logic clk;
    logic rst_n;

    icache_set_array_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .S_INDEX(S_INDEX), .WAYS(WAYS)) bus ();

    icache_set_array #(.WIDTH(WIDTH), .TAG_W(TAG_W), .S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         fe;
        logic [5:0]   wi;
        logic [1:0]   fw;
        logic [23:0]  ft;
        logic [255:0] fd;
        logic [5:0]   ri;
        logic [23:0]  rt;
        logic         ae;
        logic         eh;
        logic [1:0]   ew;
        logic [255:0] ed;
        logic [1:0]   ev;
    } vec_t;

    typedef struct {
        string        name;
        logic         hit;
        logic [1:0]   way;
        logic [255:0] data;
        logic [1:0]   victim;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[19];

    function automatic logic [255:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic vec_t mkv(input logic fe, input logic [5:0] wi, input logic [1:0] fw,
                                 input logic [23:0] ft, input logic [255:0] fd,
                                 input logic [5:0] ri, input logic [23:0] rt, input logic ae,
                                 input logic eh, input logic [1:0] ew, input logic [255:0] ed,
                                 input logic [1:0] ev);
        vec_t v;
        v.fe = fe; v.wi = wi; v.fw = fw; v.ft = ft; v.fd = fd;
        v.ri = ri; v.rt = rt; v.ae = ae;
        v.eh = eh; v.ew = ew; v.ed = ed; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic [5:0] wi, input logic [1:0] fw,
                         input logic [23:0] ft, input logic [255:0] fd,
                         input logic [5:0] ri, input logic [23:0] rt, input logic ae);
        bus.fill_en   = fe;
        bus.windex    = wi;
        bus.fill_way  = fw;
        bus.fill_tag  = ft;
        bus.fill_data = fd;
        bus.rindex    = ri;
        bus.rtag      = rt;
        bus.access_en = ae;
    endtask

    task automatic expect_lookup(input string nm, input logic h, input logic [1:0] w,
                                 input logic [255:0] d, input logic [1:0] v);
        exp_t e;
        e.name = nm; e.hit = h; e.way = w; e.data = d; e.victim = v;
        sb_q.push_back(e);
    endtask

    task automatic compare_lookup();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 256'(1), 256'(0));
        end else begin
            e = sb_q.pop_front();
            $display("%s: hit=%0d way=%0d victim=%0d (exp %0d/%0d/%0d)", e.name,
                     bus.hit, bus.hit_way, bus.victim_way, e.hit, e.way, e.victim);
            chk({e.name, "_hit"},    256'(bus.hit),        256'(e.hit));
            chk({e.name, "_way"},    256'(bus.hit_way),    256'(e.way));
            chk({e.name, "_rdata"},  bus.rdata,            e.data);
            chk({e.name, "_victim"}, 256'(bus.victim_way), 256'(e.victim));
        end
    endtask

    task automatic look_miss(input string nm, input logic [5:0] ri, input logic [23:0] rt);
        @(negedge clk);
        drive(1'b0, 6'd0, 2'd0, 24'd0, 256'd0, ri, rt, 1'b0);
        #1;
        expect_lookup(nm, 1'b0, 2'd0, 256'd0, 2'd0);
        compare_lookup();
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;

    initial begin
        vecs[0]  = mkv(0, 0, 0, 24'h0,      256'd0,      5,  24'h000ABC, 0, 0, 0, 256'd0,      0);
        vecs[1]  = mkv(1, 5, 1, 24'h123456, D_BEEF,      6,  24'h123456, 0, 0, 0, 256'd0,      0);
        vecs[2]  = mkv(0, 0, 0, 24'h0,      256'd0,      5,  24'h123456, 0, 1, 1, D_BEEF,      0);
        vecs[3]  = mkv(0, 0, 0, 24'h0,      256'd0,      6,  24'h123456, 0, 0, 0, 256'd0,      0);
        vecs[4]  = mkv(1, 9, 0, 24'h77,     pat(8'h77),  9,  24'h77,     0, 1, 0, pat(8'h77),  1);
        vecs[5]  = mkv(0, 0, 0, 24'h0,      256'd0,      9,  24'h77,     0, 1, 0, pat(8'h77),  1);
        vecs[6]  = mkv(1, 3, 0, 24'h300,    pat(8'h30),  3,  24'h300,    0, 1, 0, pat(8'h30),  1);
        vecs[7]  = mkv(1, 3, 1, 24'h301,    pat(8'h31),  3,  24'h300,    0, 1, 0, pat(8'h30),  2);
        vecs[8]  = mkv(1, 3, 2, 24'h302,    pat(8'h32),  3,  24'h300,    0, 1, 0, pat(8'h30),  3);
        vecs[9]  = mkv(1, 3, 3, 24'h303,    pat(8'h33),  3,  24'h300,    0, 1, 0, pat(8'h30),  0);
        vecs[10] = mkv(0, 0, 0, 24'h0,      256'd0,      3,  24'h300,    1, 1, 0, pat(8'h30),  0);
        vecs[11] = mkv(0, 0, 0, 24'h0,      256'd0,      3,  24'h302,    1, 1, 2, pat(8'h32),  2);
        vecs[12] = mkv(0, 0, 0, 24'h0,      256'd0,      3,  24'h300,    0, 1, 0, pat(8'h30),  1);
        vecs[13] = mkv(1, 3, 1, 24'h311,    pat(8'h41),  3,  24'h303,    1, 1, 3, pat(8'h33),  1);
        vecs[14] = mkv(0, 0, 0, 24'h0,      256'd0,      3,  24'h311,    0, 1, 1, pat(8'h41),  2);
        vecs[15] = mkv(0, 0, 0, 24'h0,      256'd0,      3,  24'h301,    0, 0, 0, 256'd0,      2);
        vecs[16] = mkv(1, 10, 2, 24'h55,    pat(8'h52),  10, 24'h55,     0, 1, 2, pat(8'h52),  0);
        vecs[17] = mkv(1, 10, 1, 24'h55,    pat(8'h51),  10, 24'h55,     0, 1, 1, pat(8'h51),  0);
        vecs[18] = mkv(0, 0, 0, 24'h0,      256'd0,      10, 24'h55,     0, 1, 1, pat(8'h51),  0);

        rst_n         = 1'b0;
        bus.flush_req = 1'b0;
        drive(1'b0, 6'd0, 2'd0, 24'd0, 256'd0, 6'd0, 24'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy",       256'(bus.busy),       256'(0));
        chk("reset_flush_done", 256'(bus.flush_done), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table: lookup sampled before the edge that commits the fill/touch.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].fe, vecs[i].wi, vecs[i].fw, vecs[i].ft, vecs[i].fd,
                  vecs[i].ri, vecs[i].rt, vecs[i].ae);
            #1;
            expect_lookup($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ew, vecs[i].ed, vecs[i].ev);
            compare_lookup();
        end

        // Flush sweep with a fill and a lookup attempted while busy.
        @(negedge clk);
        drive(1'b0, 6'd0, 2'd0, 24'd0, 256'd0, 6'd5, 24'h123456, 1'b0);
        bus.flush_req = 1'b1;
        #1;
        chk("pre_flush_busy", 256'(bus.busy), 256'(0));
        @(negedge clk);
        bus.flush_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < 100; c++) begin
            if (c == 3) begin
                drive(1'b1, 6'd1, 2'd0, 24'h99, pat(8'h99), 6'd1, 24'h99, 1'b1);
            end else if (c == 4) begin
                drive(1'b0, 6'd0, 2'd0, 24'd0, 256'd0, 6'd5, 24'h123456, 1'b1);
            end
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.flush_done) begin
                done_cnt++;
                done_at = c;
            end
            if (c == 3) begin
                chk("flush_fwd_hit",   256'(bus.hit), 256'(0));
                chk("flush_fwd_rdata", bus.rdata,     256'd0);
            end
            if (c == 4) begin
                chk("flush_masked_hit",   256'(bus.hit), 256'(0));
                chk("flush_masked_rdata", bus.rdata,     256'd0);
            end
            @(negedge clk);
        end
        $display("flush: busy_cycles=%0d done_pulses=%0d done_at=%0d", busy_cnt, done_cnt, done_at);
        chk("flush_busy_cycles", 256'(busy_cnt), 256'(SETS));
        chk("flush_done_count",  256'(done_cnt), 256'(1));
        chk("flush_done_cycle",  256'(done_at),  256'(SETS));

        look_miss("post_flush_s5",    6'd5,  24'h123456);
        look_miss("post_flush_s9",    6'd9,  24'h77);
        look_miss("post_flush_s3w0",  6'd3,  24'h300);
        look_miss("post_flush_s3w2",  6'd3,  24'h302);
        look_miss("post_flush_s3w3",  6'd3,  24'h303);
        look_miss("post_flush_s3w1",  6'd3,  24'h311);
        look_miss("post_flush_s10",   6'd10, 24'h55);
        look_miss("fill_during_busy", 6'd1,  24'h99);

        // Reset in the middle of a sweep.
        @(negedge clk);
        drive(1'b1, 6'd5, 2'd1, 24'h123456, D_BEEF, 6'd0, 24'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 6'd40, 2'd2, 24'hAA, pat(8'hAA), 6'd0, 24'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 6'd0, 2'd0, 24'd0, 256'd0, 6'd40, 24'hAA, 1'b0);
        #1;
        expect_lookup("refill_s40", 1'b1, 2'd2, pat(8'hAA), 2'd0);
        compare_lookup();
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("busy_before_reset", 256'(bus.busy), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("reset_mid_busy", 256'(bus.busy),       256'(0));
        chk("reset_mid_done", 256'(bus.flush_done), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.flush_done) done_cnt++;
        end
        $display("after reset: busy_cycles=%0d done_pulses=%0d", busy_cnt, done_cnt);
        chk("reset_abort_busy", 256'(busy_cnt), 256'(0));
        chk("reset_abort_done", 256'(done_cnt), 256'(0));
        look_miss("reset_miss_s5",  6'd5,  24'h123456);
        look_miss("reset_miss_s40", 6'd40, 24'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
